// File: rtl/inst_retire_fifo_if.sv
// Retire-trace handshake bundle between WB (master) and inst_retire_fifo (slave).
interface inst_retire_fifo_if #(
  parameter int DEPTH   = 8,
  parameter int DATA_WD = 70
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               inst_retire_valid;
  logic [DATA_WD-1:0] inst_retired;
  logic               inst_retired_fifo_full;
  logic               retire_out_valid;
  logic [DATA_WD-1:0] retire_out_data;
  logic               retire_out_ready;
  logic [CW-1:0]      fifo_count;
  logic               fifo_overflow;

  modport master (
    output inst_retire_valid, inst_retired, retire_out_ready,
    input  inst_retired_fifo_full, retire_out_valid, retire_out_data, fifo_count, fifo_overflow
  );

  modport slave (
    input  inst_retire_valid, inst_retired, retire_out_ready,
    output inst_retired_fifo_full, retire_out_valid, retire_out_data, fifo_count, fifo_overflow
  );
endinterface

// File: rtl/inst_retire_fifo.sv
// Retire-trace FIFO behind WB with early full for registered WB valid.
// RETIRE_FIFO_FWFT_EN selects first-word-fall-through; default is a registered output stage.
module inst_retire_fifo #(
  parameter int DEPTH       = 8,
  parameter int DATA_WD     = 70,
  parameter int FULL_MARGIN = 1
) (
  input logic              clk,
  input logic              rst,
  inst_retire_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WD-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               push, pop;
`ifndef RETIRE_FIFO_FWFT_EN
  logic               ovalid_q, ovalid_d;
  logic [DATA_WD-1:0] oreg_q, oreg_d;
`endif

  always_comb begin
`ifdef RETIRE_FIFO_FWFT_EN
    pop = (count_q != '0) && bus.retire_out_ready;
`else
    // Refill the output register whenever it is empty or being drained.
    pop      = (count_q != '0) && (!ovalid_q || bus.retire_out_ready);
    ovalid_d = ovalid_q;
    oreg_d   = oreg_q;
    if (pop) begin
      oreg_d   = mem_q[rptr_q];
      ovalid_d = 1'b1;
    end else if (ovalid_q && bus.retire_out_ready && count_q == '0) begin
      ovalid_d = 1'b0;
    end
`endif
    push    = bus.inst_retire_valid && ((count_q < CW'(DEPTH)) || pop);
    ovf_d   = ovf_q | (bus.inst_retire_valid & ~push);
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= bus.inst_retired;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
`ifndef RETIRE_FIFO_FWFT_EN
      ovalid_q <= 1'b0;
      oreg_q   <= '0;
`endif
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
`ifndef RETIRE_FIFO_FWFT_EN
      ovalid_q <= ovalid_d;
      oreg_q   <= oreg_d;
`endif
    end
  end

  // Full depends only on the count register, so WB sees no combinational path.
  assign bus.inst_retired_fifo_full = int'(count_q) >= (DEPTH - FULL_MARGIN);
  assign bus.fifo_count             = count_q;
  assign bus.fifo_overflow          = ovf_q;
`ifdef RETIRE_FIFO_FWFT_EN
  assign bus.retire_out_valid = (count_q != '0);
  assign bus.retire_out_data  = (count_q != '0) ? mem_q[rptr_q] : '0;
`else
  assign bus.retire_out_valid = ovalid_q;
  assign bus.retire_out_data  = oreg_q;
`endif
endmodule

// File: tb/tb_inst_retire_fifo.sv
// Randomized and directed checks of inst_retire_fifo against a queue-based reference.
module tb_inst_retire_fifo;
  localparam int DEPTH = 4;
  localparam int DW    = 70;
  localparam int FM    = 1;
`ifdef RETIRE_FIFO_FWFT_EN
  localparam int OR = 0;
`else
  localparam int OR = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [DW-1:0] got [$];

  always #5 clk = ~clk;

  inst_retire_fifo_if #(.DEPTH(DEPTH), .DATA_WD(DW)) bus ();
  inst_retire_fifo #(.DEPTH(DEPTH), .DATA_WD(DW), .FULL_MARGIN(FM)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  function automatic logic [DW-1:0] rec(input logic [31:0] pc);
    return {pc, 1'b1, pc[6:2], ~pc};
  endfunction

  // Called just after a negedge; records the handshake that the next posedge completes.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic rdy);
    bus.inst_retire_valid = v;
    bus.inst_retired      = v ? rec(pc) : '0;
    bus.retire_out_ready  = rdy;
    if (!rst && bus.retire_out_valid && rdy) got.push_back(bus.retire_out_data);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cycle(1'b1, 32'h55, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.fifo_count); end
    checks++; if (bus.retire_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.retire_out_valid); end
    checks++; if (bus.inst_retired_fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.inst_retired_fifo_full); end
    checks++; if (bus.fifo_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.fifo_overflow); end
    checks++; if (bus.retire_out_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", bus.retire_out_data); end
  endtask

  task automatic test_fill_drain;
    logic [31:0] pl [5];
    int r, ex, dead;
    pl = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010};
    got.delete();
    cycle(1'b1, pl[0], 1'b0);
    checks++; if (bus.retire_out_valid !== (OR == 0)) begin errors++; $display("FAIL latency_1 got %b want %b", bus.retire_out_valid, OR == 0); end
    cycle(1'b1, pl[1], 1'b0);
    checks++; if (bus.retire_out_valid !== 1'b1) begin errors++; $display("FAIL latency_2 got %b want 1", bus.retire_out_valid); end
    for (int i = 2; i < 3 + OR; i++) cycle(1'b1, pl[i], 1'b0);
    checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL fill_count got %0d want 3", bus.fifo_count); end
    checks++; if (bus.inst_retired_fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", bus.inst_retired_fifo_full); end
    cycle(1'b1, pl[3 + OR], 1'b0);
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL absorb_count got %0d want 4", bus.fifo_count); end
    checks++; if (bus.fifo_overflow !== 1'b0) begin errors++; $display("FAIL absorb_ovf got %b want 0", bus.fifo_overflow); end
    cycle(1'b1, 32'hDEAD, 1'b0);
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL drop_count got %0d want 4", bus.fifo_count); end
    checks++; if (bus.fifo_overflow !== 1'b1) begin errors++; $display("FAIL drop_ovf got %b want 1", bus.fifo_overflow); end
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 32'h0, 1'b1);
      r  = 4 + OR - got.size();
      ex = (r - OR > 0) ? r - OR : 0;
      checks++; if (int'(bus.fifo_count) != ex) begin errors++; $display("FAIL drain_count cyc %0d got %0d want %0d", k, bus.fifo_count, ex); end
      checks++; if (bus.inst_retired_fifo_full !== (ex >= DEPTH - FM)) begin errors++; $display("FAIL drain_full cyc %0d got %b want %b", k, bus.inst_retired_fifo_full, ex >= DEPTH - FM); end
      checks++; if (bus.retire_out_valid !== (r > 0)) begin errors++; $display("FAIL drain_valid cyc %0d got %b want %b", k, bus.retire_out_valid, r > 0); end
    end
    checks++; if (got.size() != 4 + OR) begin errors++; $display("FAIL drain_size got %0d want %0d", got.size(), 4 + OR); end
    dead = 0;
    for (int i = 0; i < got.size(); i++) begin
      if (got[i][69:38] == 32'hDEAD) dead++;
      if (i < 4 + OR) begin
        checks++; if (got[i] !== rec(pl[i])) begin errors++; $display("FAIL drain_order idx %0d got %h want %h", i, got[i], rec(pl[i])); end
      end
    end
    checks++; if (dead != 0) begin errors++; $display("FAIL drain_dead got %0d want 0", dead); end
    checks++; if (bus.fifo_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus.fifo_overflow); end
  endtask

  task automatic test_reset_mid;
    got.delete();
    for (int i = 0; i < 3 + OR; i++) cycle(1'b1, 32'h5000 + 32'(4 * i), 1'b0);
    checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL rmid_pre_count got %0d want 3", bus.fifo_count); end
    rst = 1'b1;
    cycle(1'b1, 32'h4444, 1'b0);
    rst = 1'b0;
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", bus.fifo_count); end
    checks++; if (bus.retire_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", bus.retire_out_valid); end
    checks++; if (bus.inst_retired_fifo_full !== 1'b0) begin errors++; $display("FAIL rmid_full got %b want 0", bus.inst_retired_fifo_full); end
    checks++; if (bus.fifo_overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %b want 0", bus.fifo_overflow); end
    for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 1'b1);
    checks++; if (got.size() != 0) begin errors++; $display("FAIL rmid_stale got %0d want 0", got.size()); end
    checks++; if (bus.retire_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid_late got %b want 0", bus.retire_out_valid); end
  endtask

  task automatic test_full_pushpop;
    rst = 1'b1; cycle(1'b0, 32'h0, 1'b0); rst = 1'b0;
    got.delete();
    for (int i = 0; i < 4 + OR; i++) cycle(1'b1, 32'h3000 + 32'(4 * i), 1'b0);
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL pp_pre_count got %0d want 4", bus.fifo_count); end
    cycle(1'b1, 32'h3000 + 32'(4 * (4 + OR)), 1'b1);
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL pp_count got %0d want 4", bus.fifo_count); end
    checks++; if (bus.fifo_overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf got %b want 0", bus.fifo_overflow); end
    for (int k = 0; k < 10; k++) cycle(1'b0, 32'h0, 1'b1);
    checks++; if (got.size() != 5 + OR) begin errors++; $display("FAIL pp_size got %0d want %0d", got.size(), 5 + OR); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== rec(32'h3000 + 32'(4 * i))) begin errors++; $display("FAIL pp_order idx %0d got %h want %h", i, got[i], rec(32'h3000 + 32'(4 * i))); end
    end
  endtask

  task automatic test_wrap;
    int maxc;
    got.delete();
    maxc = 0;
    for (int k = 0; k < 10 + 1 + OR; k++) begin
      if (k < 10) cycle(1'b1, 32'h2000 + 32'(4 * k), 1'b1);
      else        cycle(1'b0, 32'h0, 1'b1);
      if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
    end
    checks++; if (maxc > 2) begin errors++; $display("FAIL wrap_count got %0d want <=2", maxc); end
    checks++; if (got.size() != 10) begin errors++; $display("FAIL wrap_throughput got %0d want 10", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== rec(32'h2000 + 32'(4 * i))) begin errors++; $display("FAIL wrap_order idx %0d got %h want %h", i, got[i], rec(32'h2000 + 32'(4 * i))); end
    end
    checks++; if (bus.fifo_overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %b want 0", bus.fifo_overflow); end
  endtask

  task automatic test_random;
    logic [DW-1:0] exp_q [$];
    logic          v, rdy;
    logic [31:0]   pc;
    int            total, bad;
    got.delete();
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      v   = !bus.inst_retired_fifo_full && ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 3) != 0);
      pc  = $urandom;
      if (v) exp_q.push_back(rec(pc));
      cycle(v, pc, rdy);
      total = exp_q.size() - got.size();
      // Items in flight are either in storage or, for the registered build, in the output slot.
      if (int'(bus.fifo_count) + (OR == 1 ? int'(bus.retire_out_valid) : 0) != total) bad++;
      if (OR == 0 && bus.retire_out_valid !== (total != 0)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_occupancy bad cycles %0d want 0", bad); end
    for (int k = 0; k < 12; k++) cycle(1'b0, 32'h0, 1'b1);
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rand_size got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rand_order idx %0d got %h want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (bus.fifo_overflow !== 1'b0) begin errors++; $display("FAIL rand_ovf got %b want 0", bus.fifo_overflow); end
  endtask

  initial begin
    rst = 1'b1;
    bus.inst_retire_valid = 1'b0;
    bus.inst_retired      = '0;
    bus.retire_out_ready  = 1'b0;
    @(negedge clk);
    test_reset;
    test_fill_drain;
    test_reset_mid;
    test_full_pushpop;
    test_wrap;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
